// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Shares the single-ported 4Kx32 data RAM between the processor
//             data port (port 0, fixed priority) and a secondary requester
//             (port 1, e.g. debug loader / DMA). A saturating starvation
//             counter forces a port-1 grant after STARVE_LIMIT consecutive
//             denied cycles. Read data returns one cycle after the grant,
//             tagged to the port that issued the read.
//  Ports    :
//    clock, reset             - clock, asynchronous active-low reset
//    pN_req/wen/addr/wdata    - port N command (held until granted)
//    pN_gnt                   - port N command accepted this cycle
//    pN_rvalid/rdata          - port N read return (cycle after grant)
//    ram_wEn/addr/dataIn      - RAM command for the granted port
//    ram_dataOut              - registered RAM read data
//    starved                  - port 1 granted by the starvation override
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_wen,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_wen,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              ram_wEn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dataIn,
    input  logic [DATA_W-1:0] ram_dataOut,
    output logic              starved
);

    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

    // rd_pend encoding: bit0 = read outstanding, bit1 = issuing port
    localparam logic [1:0] C_PEND_NONE = 2'b00;
    localparam logic [1:0] C_PEND_P0   = 2'b01;
    localparam logic [1:0] C_PEND_P1   = 2'b11;

    logic [3:0] r_starve_cnt;
    logic [1:0] r_rd_pend;

    logic       w_override;
    logic       w_gnt0;
    logic       w_gnt1;
    logic [3:0] w_starve_cnt_nxt;
    logic [1:0] w_rd_pend_nxt;

    // ------------------------------------------------------------------------
    // Arbitration. Grants are gated by reset so nothing reaches the RAM while
    // reset is held, even though the request inputs may be active.
    // ------------------------------------------------------------------------
    always_comb begin
        w_override = reset && p1_req && (r_starve_cnt == C_STARVE_LIMIT);
        w_gnt0     = reset && p0_req && !w_override;
        w_gnt1     = w_override || (reset && p1_req && !p0_req);
    end

    assign p0_gnt  = w_gnt0;
    assign p1_gnt  = w_gnt1;
    assign starved = w_override;

    // RAM command mux; idle cycles drive all-zero command
    always_comb begin
        ram_wEn    = 1'b0;
        ram_addr   = '0;
        ram_dataIn = '0;
        if (w_gnt0) begin
            ram_wEn    = p0_wen;
            ram_addr   = p0_addr;
            ram_dataIn = p0_wdata;
        end else if (w_gnt1) begin
            ram_wEn    = p1_wen;
            ram_addr   = p1_addr;
            ram_dataIn = p1_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Starvation counter: counts denied port-1 cycles, saturating at the
    // limit; any grant to port 1 or a withdrawn request restarts it.
    // ------------------------------------------------------------------------
    always_comb begin
        w_starve_cnt_nxt = 4'd0;
        if (p1_req && !w_gnt1) begin
            if (r_starve_cnt == C_STARVE_LIMIT) begin
                w_starve_cnt_nxt = r_starve_cnt;
            end else begin
                w_starve_cnt_nxt = r_starve_cnt + 4'd1;
            end
        end
    end

    // Read return tag for the cycle after a granted read
    always_comb begin
        w_rd_pend_nxt = C_PEND_NONE;
        if (w_gnt0 && !p0_wen) begin
            w_rd_pend_nxt = C_PEND_P0;
        end else if (w_gnt1 && !p1_wen) begin
            w_rd_pend_nxt = C_PEND_P1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= 4'd0;
            r_rd_pend    <= C_PEND_NONE;
        end else begin
            r_starve_cnt <= w_starve_cnt_nxt;
            r_rd_pend    <= w_rd_pend_nxt;
        end
    end

    // Read data steering; the non-addressed port sees zero
    always_comb begin
        p0_rvalid = (r_rd_pend == C_PEND_P0);
        p1_rvalid = (r_rd_pend == C_PEND_P1);
        p0_rdata  = p0_rvalid ? ram_dataOut : '0;
        p1_rdata  = p1_rvalid ? ram_dataOut : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Directed self-checking bench for dmem_arbiter with a simple
//             registered-read RAM model attached to the RAM command port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              p0_req, p0_wen, p1_req, p1_wen;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [DATA_W-1:0] p0_wdata, p1_wdata;
    logic              p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DATA_W-1:0] p0_rdata, p1_rdata;
    logic              ram_wEn;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dataIn;
    logic [DATA_W-1:0] ram_dataOut;
    logic              starved;

    logic [DATA_W-1:0] mem [0:4095];

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .p0_req     (p0_req),
        .p0_wen     (p0_wen),
        .p0_addr    (p0_addr),
        .p0_wdata   (p0_wdata),
        .p0_gnt     (p0_gnt),
        .p0_rvalid  (p0_rvalid),
        .p0_rdata   (p0_rdata),
        .p1_req     (p1_req),
        .p1_wen     (p1_wen),
        .p1_addr    (p1_addr),
        .p1_wdata   (p1_wdata),
        .p1_gnt     (p1_gnt),
        .p1_rvalid  (p1_rvalid),
        .p1_rdata   (p1_rdata),
        .ram_wEn    (ram_wEn),
        .ram_addr   (ram_addr),
        .ram_dataIn (ram_dataIn),
        .ram_dataOut(ram_dataOut),
        .starved    (starved)
    );

    // Single-ported RAM model: write on wEn, read data registered
    always @(posedge clock) begin
        if (ram_wEn) mem[ram_addr] <= ram_dataIn;
        ram_dataOut <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic idle();
        p0_req = 1'b0; p0_wen = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_wen = 1'b0; p1_addr = '0; p1_wdata = '0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[12'h001] = 32'h0000_0001;
        mem[12'h002] = 32'h0000_0002;
        mem[12'hFFF] = 32'h1234_5678;
        ram_dataOut  = '0;

        // ---- reset held with both ports requesting (p0 a write) ----
        reset = 1'b0;
        idle();
        p0_req = 1'b1; p0_wen = 1'b1; p0_addr = 12'h001; p0_wdata = 32'hBAD0_BAD0;
        p1_req = 1'b1; p1_addr = 12'h002;
        settle();
        check("rst_p0_gnt",    p0_gnt,    0);
        check("rst_p1_gnt",    p1_gnt,    0);
        check("rst_ram_wEn",   ram_wEn,   0);
        check("rst_p0_rvalid", p0_rvalid, 0);
        check("rst_p1_rvalid", p1_rvalid, 0);
        check("rst_starved",   starved,   0);
        tick();
        p0_wen = 1'b0;              // switch to a read of 0x001
        reset  = 1'b1;
        settle();
        check("rel_p0_gnt", p0_gnt, 1);
        check("rel_p1_gnt", p1_gnt, 0);
        tick();
        idle();
        settle();
        check("rel_p0_rvalid", p0_rvalid, 1);
        check("rel_p0_rdata",  p0_rdata,  32'h0000_0001);
        check("rel_mem_kept",  mem[12'h001], 32'h0000_0001);
        tick();

        // ---- port 0 write then read ----
        p0_req = 1'b1; p0_wen = 1'b1; p0_addr = 12'h010; p0_wdata = 32'hDEAD_BEEF;
        settle();
        check("wr_p0_gnt",     p0_gnt,     1);
        check("wr_ram_wEn",    ram_wEn,    1);
        check("wr_ram_addr",   ram_addr,   32'h010);
        check("wr_ram_dataIn", ram_dataIn, 32'hDEAD_BEEF);
        tick();
        p0_wen = 1'b0; p0_wdata = '0;
        settle();
        check("rd_p0_gnt",      p0_gnt,    1);
        check("rd_ram_wEn",     ram_wEn,   0);
        check("wr_no_rvalid",   p0_rvalid, 0);
        tick();
        idle();
        settle();
        check("rd_p0_rvalid",  p0_rvalid, 1);
        check("rd_p0_rdata",   p0_rdata,  32'hDEAD_BEEF);
        check("rd_p1_rvalid",  p1_rvalid, 0);
        check("rd_p1_rdata",   p1_rdata,  0);
        check("idle_ram_addr", ram_addr,  0);
        tick();

        // ---- port 1 alone ----
        p1_req = 1'b1; p1_addr = 12'hFFF;
        settle();
        check("p1_gnt",     p1_gnt,  1);
        check("p1_p0_gnt",  p0_gnt,  0);
        check("p1_starved", starved, 0);
        check("p1_ram_addr", ram_addr, 32'hFFF);
        tick();
        idle();
        settle();
        check("p1_rvalid",    p1_rvalid, 1);
        check("p1_rdata",     p1_rdata,  32'h1234_5678);
        check("p1_p0_rvalid", p0_rvalid, 0);
        tick();

        // ---- starvation: both request continuously, period 5 ----
        for (int i = 0; i < 10; i++) begin
            p0_req = 1'b1; p0_addr = 12'h001;
            p1_req = 1'b1; p1_addr = 12'h002;
            settle();
            check($sformatf("stv_p0_gnt_%0d", i),  p0_gnt,  (i % 5) != 4);
            check($sformatf("stv_p1_gnt_%0d", i),  p1_gnt,  (i % 5) == 4);
            check($sformatf("stv_starved_%0d", i), starved, (i % 5) == 4);
            check($sformatf("stv_p0_rv_%0d", i), p0_rvalid, (i > 0) && (((i - 1) % 5) != 4));
            check($sformatf("stv_p1_rv_%0d", i), p1_rvalid, (i > 0) && (((i - 1) % 5) == 4));
            if (p0_rvalid) check($sformatf("stv_p0_rd_%0d", i), p0_rdata, 32'h1);
            if (p1_rvalid) check($sformatf("stv_p1_rd_%0d", i), p1_rdata, 32'h2);
            tick();
        end
        idle();
        settle();
        check("stv_last_p1_rv", p1_rvalid, 1);
        check("stv_last_p1_rd", p1_rdata,  32'h2);
        tick();

        // ---- alternating reads ----
        p0_req = 1'b1; p0_addr = 12'h001;
        p1_req = 1'b1; p1_addr = 12'h002;
        settle();
        check("alt_a_p0_gnt", p0_gnt, 1);
        check("alt_a_p1_gnt", p1_gnt, 0);
        tick();
        p0_req = 1'b0; p0_addr = '0;
        settle();
        check("alt_b_p1_gnt",    p1_gnt,    1);
        check("alt_b_starved",   starved,   0);
        check("alt_b_p0_rvalid", p0_rvalid, 1);
        check("alt_b_p0_rdata",  p0_rdata,  32'h1);
        check("alt_b_p1_rvalid", p1_rvalid, 0);
        tick();
        idle();
        settle();
        check("alt_c_p1_rvalid", p1_rvalid, 1);
        check("alt_c_p1_rdata",  p1_rdata,  32'h2);
        check("alt_c_p0_rvalid", p0_rvalid, 0);
        tick();

        // ---- reset in the cycle after a granted read ----
        p0_req = 1'b1; p0_addr = 12'h010;
        p1_req = 1'b1; p1_addr = 12'h002;
        settle();
        check("mid_p0_gnt", p0_gnt, 1);
        tick();
        reset = 1'b0;
        settle();
        check("mid_p0_rvalid", p0_rvalid, 0);
        check("mid_p1_rvalid", p1_rvalid, 0);
        check("mid_p0_rdata",  p0_rdata,  0);
        check("mid_p0_gnt_r",  p0_gnt,    0);
        check("mid_p1_gnt_r",  p1_gnt,    0);
        check("mid_starve_cnt", {28'd0, dut.r_starve_cnt}, 0);
        tick();
        idle();
        reset = 1'b1;
        settle();
        check("post_p0_rvalid_0", p0_rvalid, 0);
        check("post_p1_rvalid_0", p1_rvalid, 0);
        tick();
        settle();
        check("post_p0_rvalid_1", p0_rvalid, 0);
        check("post_p1_rvalid_1", p1_rvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported 4K×32 data RAM between the processor's data-memory port (port 0) and a secondary requester such as a debug loader or DMA engine (port 1). Port 0 has fixed priority. A starvation counter guarantees that port 1 is eventually granted. The arbiter sits between the processor/secondary master and the RAM inside the top-level wrapper. It serialises all accesses, drives the RAM command for the granted port, and routes read data back with a one-cycle-late valid strobe to the port that issued the read.

## Interface
- ADDR_W, 12, RAM word-address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive denied cycles of port 1 before port 1 is forced a grant (legal range 1..15).

- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- p0_req  in  1  port 0 access request; held stable with its command until granted.
- p0_wen  in  1  port 0 write (1) / read (0).
- p0_addr  in  ADDR_W  port 0 word address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_gnt  out  1  port 0 command accepted this cycle.
- p0_rvalid  out  1  port 0 read data valid.
- p0_rdata  out  DATA_W  port 0 read data.
- p1_req, p1_wen, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- ram_wEn  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_dataIn  out  DATA_W  RAM write data.
- ram_dataOut  in  DATA_W  RAM read data; registered by the RAM, valid one cycle after the address is sampled.
- starved  out  1  high on any cycle in which port 1 is granted by the starvation override.

## Operation
- Each cycle grants at most one port. Grant is combinational from the current cycle's req inputs and the registered starvation count.
- Arbitration, evaluated in this order:
  - If p1_req=1 and starve_cnt==STARVE_LIMIT, grant port 1 and set starved=1.
  - Otherwise, if p0_req=1, grant port 0.
  - Otherwise, if p1_req=1, grant port 1.
  - Otherwise, grant none.
- RAM command in a granted cycle: ram_addr, ram_dataIn and ram_wEn are taken from the granted port, with ram_wEn = that port's wen.
- RAM command in a cycle with no grant: ram_wEn=0, and ram_addr and ram_dataIn hold 0.
- starve_cnt is a 4-bit register.
  - It increments, saturating at STARVE_LIMIT, on each cycle with p1_req=1 and p1_gnt=0.
  - It clears to 0 on p1_gnt=1 or p1_req=0.
- Read return tracking:
  - A 2-bit register rd_pend is set to {port, 1} on a granted read and to 0 otherwise.
  - In the following cycle the pending port's rvalid=1 and its rdata=ram_dataOut.
  - The other port's rvalid=0 and its rdata=0.
- Writes produce no rvalid.
- Ordering follows grant order. A read granted the cycle after a write to the same address returns the new data.
- Requesters must not change a command while req=1 and gnt=0. They may withdraw req at any time before grant.

## Timing
- Reset values: p0_gnt=p1_gnt=0, p0_rvalid=p1_rvalid=0, rdata=0, ram_wEn=0, starved=0, starve_cnt=0, rd_pend=0.
- While reset=0, grants are forced to 0. Any read in flight is discarded, and no rvalid follows the release of reset.
- Grant latency:
  - 0 cycles for port 0, when STARVE_LIMIT is not hit.
  - At most STARVE_LIMIT+1 cycles for port 1 under continuous port-0 load.
- Read latency: rvalid is asserted exactly 1 cycle after the gnt cycle.
- Throughput is one access per cycle, and back-to-back reads from alternating ports are allowed.
- Simultaneous requests: port 0 wins unless the starvation override is active. In the override cycle p0_gnt=0 and port 0 retries next cycle.
- After an override grant, starve_cnt returns to 0. Port 0 regains priority on the next cycle.

## Test plan
- Reset: hold reset=0 with both ports requesting -> both gnt=0, ram_wEn=0, both rvalid=0. Release reset -> p0_gnt=1 in the first cycle.
- Port 0 write then read:
  - Write 0xDEADBEEF to address 0x010; next cycle read 0x010 -> p0_gnt=1 both cycles.
  - p0_rvalid=1 with p0_rdata=0xDEADBEEF on the cycle after the read grant; p1_rvalid stays 0.
- Port 1 alone: read address 0xFFF, preloaded with 0x12345678 -> p1_gnt=1 immediately, p1_rvalid=1 and p1_rdata=0x12345678 the next cycle.
- Starvation, STARVE_LIMIT=4: both ports request continuously -> p0_gnt=1 for 4 cycles, then p1_gnt=1 with starved=1 on the 5th cycle. The pattern repeats every 5 cycles.
- Alternating reads: p0 reads 0x001 (=1) while p1 reads 0x002 (=2), with port 1 granted one cycle later -> p0_rvalid then p1_rvalid on consecutive cycles with correct data; the two rvalids are never high together.
- Reset mid-read: assert reset=0 in the cycle after a granted read -> rvalid stays 0 and starve_cnt=0. After release, no stale rvalid appears.
